// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - evaluates digit ((+|*) digit)* '=' with '*' before '+'
// One ASCII char per valid cycle; a one-cycle result pulse follows the '='.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic             ovf,
  output logic             busy
);

  localparam int XW = WIDTH + 4;

  typedef enum logic [1:0] {S_IDLE, S_OP, S_DIG, S_ERR} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sum_q, prod_q, result_q;
  logic             mul_pend_q, ovf_acc_q;
  logic             result_valid_q, err_q, ovf_q, busy_q;

  logic             is_digit, is_add, is_mul, is_term;
  logic [7:0]       dsub;
  logic [3:0]       dval;
  logic [XW-1:0]    prod_x, sum_x;
  logic             prod_ovf, sum_ovf;

  assign is_digit = (in >= 8'd48) && (in <= 8'd57);
  assign is_add   = (in == 8'd43);
  assign is_mul   = (in == 8'd42);
  assign is_term  = (in == 8'd61);
  assign dsub     = in - 8'd48;
  assign dval     = dsub[3:0];

  // Widened arithmetic so carries past WIDTH can be detected before truncation.
  assign prod_x   = {4'b0, prod_q} * {{(XW-4){1'b0}}, dval};
  assign sum_x    = {4'b0, sum_q} + {4'b0, prod_q};
  assign prod_ovf = |prod_x[XW-1:WIDTH];
  assign sum_ovf  = |sum_x[XW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= S_IDLE;
      sum_q          <= '0;
      prod_q         <= '0;
      result_q       <= '0;
      mul_pend_q     <= 1'b0;
      ovf_acc_q      <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      ovf_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      ovf_q          <= 1'b0;
      if (in_valid) begin
        case (state_q)
          S_IDLE: begin
            if (is_digit) begin
              prod_q    <= {{(WIDTH-4){1'b0}}, dval};
              sum_q     <= '0;
              ovf_acc_q <= 1'b0;
              state_q   <= S_OP;
              busy_q    <= 1'b1;
            end else if (is_term) begin
              result_valid_q <= 1'b1;
              err_q          <= 1'b1;
            end else begin
              state_q <= S_ERR;
              busy_q  <= 1'b1;
            end
          end
          S_OP: begin
            if (is_mul) begin
              mul_pend_q <= 1'b1;
              state_q    <= S_DIG;
            end else if (is_add) begin
              sum_q      <= sum_x[WIDTH-1:0];
              ovf_acc_q  <= ovf_acc_q | sum_ovf;
              mul_pend_q <= 1'b0;
              state_q    <= S_DIG;
            end else if (is_term) begin
              result_q       <= sum_x[WIDTH-1:0];
              result_valid_q <= 1'b1;
              ovf_q          <= ovf_acc_q | sum_ovf;
              state_q        <= S_IDLE;
              busy_q         <= 1'b0;
            end else begin
              state_q <= S_ERR;
            end
          end
          S_DIG: begin
            if (is_digit) begin
              if (mul_pend_q) begin
                prod_q    <= prod_x[WIDTH-1:0];
                ovf_acc_q <= ovf_acc_q | prod_ovf;
              end else begin
                prod_q <= {{(WIDTH-4){1'b0}}, dval};
              end
              state_q <= S_OP;
            end else if (is_term) begin
              result_valid_q <= 1'b1;
              err_q          <= 1'b1;
              state_q        <= S_IDLE;
              busy_q         <= 1'b0;
            end else begin
              state_q <= S_ERR;
            end
          end
          default: begin
            if (is_term) begin
              result_valid_q <= 1'b1;
              err_q          <= 1'b1;
              state_q        <= S_IDLE;
              busy_q         <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign ovf          = ovf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - directed self-checking bench for expr_eval
// A WIDTH=16 and a WIDTH=8 instance share the same character stream.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  in;
  logic        in_valid;
  logic [15:0] result;
  logic        result_valid, err, ovf, busy;
  logic [7:0]  r8;
  logic        rv8, err8, ovf8, busy8;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(16)) dut (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .result(result), .result_valid(result_valid), .err(err), .ovf(ovf), .busy(busy)
  );

  expr_eval #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .result(r8), .result_valid(rv8), .err(err8), .ovf(ovf8), .busy(busy8)
  );

  always @(negedge clk) if (result_valid === 1'b1) pulses++;

  task automatic drive_char(input byte c);
    in = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sends a string; the final char's pulse is observable on return.
  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      drive_char(s[i]);
      if (gaps && i != s.len() - 1) idle_cycle();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; in = 8'd0; in_valid = 1'b0;
    idle_cycle(); idle_cycle();
    clr = 1'b0;
    total++; if (result !== 16'd0) begin bad++; $display("FAIL reset_result got=%0d exp=0", result); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%0b exp=0", result_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_precedence();
    pulses = 0;
    send_str("3+4*5=", 1'b0);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL prec_rv got=%0b exp=1", result_valid); end
    total++; if (result !== 16'd23) begin bad++; $display("FAIL prec_result got=%0d exp=23", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL prec_err got=%0b exp=0", err); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL prec_ovf got=%0b exp=0", ovf); end
    idle_cycle(); idle_cycle();
    total++; if (pulses !== 1) begin bad++; $display("FAIL prec_pulses got=%0d exp=1", pulses); end
    total++; if (result !== 16'd23) begin bad++; $display("FAIL prec_hold got=%0d exp=23", result); end
  endtask

  task automatic test_gaps();
    pulses = 0;
    drive_char("2");
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gaps_busy got=%0b exp=1", busy); end
    idle_cycle();
    send_str("*3*4=", 1'b1);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL gaps_rv got=%0b exp=1", result_valid); end
    total++; if (result !== 16'd24) begin bad++; $display("FAIL gaps_result got=%0d exp=24", result); end
    idle_cycle();
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL gaps_rv_width got=%0b exp=0", result_valid); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL gaps_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_back_to_back();
    pulses = 0;
    send_str("7=", 1'b0);
    total++; if (result_valid !== 1'b1 || result !== 16'd7) begin bad++; $display("FAIL b2b_first got=%0b/%0d exp=1/7", result_valid, result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy1 got=%0b exp=0", busy); end
    drive_char("9");
    total++; if (result_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_mid got=rv%0b/busy%0b exp=rv0/busy1", result_valid, busy); end
    drive_char("=");
    total++; if (result_valid !== 1'b1 || result !== 16'd9) begin bad++; $display("FAIL b2b_second got=%0b/%0d exp=1/9", result_valid, result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy2 got=%0b exp=0", busy); end
    idle_cycle();
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_error();
    pulses = 0;
    send_str("3++4=", 1'b0);
    total++; if (result_valid !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL err_pulse got=rv%0b/err%0b exp=rv1/err1", result_valid, err); end
    total++; if (result !== 16'd9) begin bad++; $display("FAIL err_hold got=%0d exp=9", result); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL err_ovf got=%0b exp=0", ovf); end
    idle_cycle();
    total++; if (pulses !== 1) begin bad++; $display("FAIL err_pulses got=%0d exp=1", pulses); end
    drive_char("=");
    total++; if (result_valid !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL err_idle_term got=rv%0b/err%0b exp=rv1/err1", result_valid, err); end
    total++; if (result !== 16'd9 || busy !== 1'b0) begin bad++; $display("FAIL err_idle_state got=%0d/busy%0b exp=9/busy0", result, busy); end
    idle_cycle();
  endtask

  task automatic test_overflow();
    send_str("9*9*9=", 1'b0);
    total++; if (rv8 !== 1'b1 || r8 !== 8'd217) begin bad++; $display("FAIL ovf8_result got=%0b/%0d exp=1/217", rv8, r8); end
    total++; if (ovf8 !== 1'b1 || err8 !== 1'b0) begin bad++; $display("FAIL ovf8_flag got=ovf%0b/err%0b exp=ovf1/err0", ovf8, err8); end
    total++; if (result !== 16'd729 || ovf !== 1'b0) begin bad++; $display("FAIL ovf16 got=%0d/ovf%0b exp=729/ovf0", result, ovf); end
    idle_cycle();
    send_str("1=", 1'b0);
    total++; if (rv8 !== 1'b1 || r8 !== 8'd1 || ovf8 !== 1'b0) begin bad++; $display("FAIL ovf8_clear got=%0b/%0d/ovf%0b exp=1/1/ovf0", rv8, r8, ovf8); end
    idle_cycle();
  endtask

  task automatic test_clr_abort();
    pulses = 0;
    send_str("5+6", 1'b0);
    clr = 1'b1;
    idle_cycle();
    clr = 1'b0;
    total++; if (busy !== 1'b0 || result !== 16'd0) begin bad++; $display("FAIL abort_state got=busy%0b/%0d exp=busy0/0", busy, result); end
    idle_cycle();
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_nopulse got=%0d exp=0", pulses); end
    send_str("2=", 1'b0);
    total++; if (result_valid !== 1'b1 || result !== 16'd2 || err !== 1'b0) begin bad++; $display("FAIL abort_next got=%0b/%0d/err%0b exp=1/2/err0", result_valid, result, err); end
    idle_cycle();
    total++; if (pulses !== 1) begin bad++; $display("FAIL abort_pulses got=%0d exp=1", pulses); end
  endtask

  initial begin
    clr = 1'b1; in = 8'd0; in_valid = 1'b0;
    test_reset();
    test_precedence();
    test_gaps();
    test_back_to_back();
    test_error();
    test_overflow();
    test_clr_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
